// File: rtl/sfp_link_mgr.sv
// Multi-channel SFP link manager: per-channel signal-detect debounce, module ID read
// over one shared IIC master, SGMII/1000BASE-X selection and PCS/PMA reset sequencing.

module sfp_link_ch #(
    parameter int DEB_CYC = 20_000_000,
    parameter int RST_CYC = 200_000
) (
    input  logic gclk,
    input  logic grst_n,
    input  logic sig_det,
    input  logic ovr_en,
    input  logic ovr_val,
    input  logic gnt,
    input  logic rvl,
    input  logic err,
    input  logic rd_bit,
    output logic req,
    output logic sel_sgmii,
    output logic rst_act,
    output logic ready,
    output logic id_err
);

    localparam int DEB_W = $clog2(DEB_CYC) + 1;
    localparam int RST_W = $clog2(RST_CYC) + 1;

    typedef enum logic [2:0] {IDLE, DEB, REQ, RD, CHK, RST, DONE} ch_state_e;

    ch_state_e        state, state_nxt;
    logic [1:0]       sync;
    logic             sig;
    logic [DEB_W-1:0] deb_cnt, deb_nxt;
    logic [RST_W-1:0] rst_cnt, rst_nxt;
    logic             new_mode, mode_nxt;
    logic             sel_nxt, err_nxt;
    logic             ovr_q;

    assign sig = sync[1];

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            sync      <= '0;
            state     <= IDLE;
            deb_cnt   <= '0;
            rst_cnt   <= '0;
            new_mode  <= 1'b0;
            sel_sgmii <= 1'b0;
            id_err    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync      <= {sync[0], sig_det};
            state     <= state_nxt;
            deb_cnt   <= deb_nxt;
            rst_cnt   <= rst_nxt;
            new_mode  <= mode_nxt;
            sel_sgmii <= sel_nxt;
            id_err    <= err_nxt;
            ovr_q     <= ovr_val;
        end
    end

    always_comb begin
        state_nxt = state;
        deb_nxt   = deb_cnt;
        rst_nxt   = rst_cnt;
        mode_nxt  = new_mode;
        sel_nxt   = sel_sgmii;
        err_nxt   = id_err;
        case (state)
            IDLE: if (sig) begin
                state_nxt = DEB;
                deb_nxt   = DEB_W'(DEB_CYC - 1);
            end
            DEB: begin
                if (!sig) begin
                    state_nxt = IDLE;
                end else if (deb_cnt == '0) begin
                    if (ovr_en) begin
                        mode_nxt  = ovr_val;
                        state_nxt = CHK;
                    end else begin
                        state_nxt = REQ;
                    end
                end else begin
                    deb_nxt = deb_cnt - DEB_W'(1);
                end
            end
            REQ: begin
                if (!sig)     state_nxt = IDLE;
                else if (gnt) state_nxt = RD;
            end
            // A started read always runs to completion; loss of signal is honoured afterwards.
            RD: begin
                if (err) begin
                    err_nxt   = 1'b1;
                    state_nxt = sig ? DONE : IDLE;
                end else if (rvl) begin
                    err_nxt   = 1'b0;
                    mode_nxt  = rd_bit;
                    state_nxt = sig ? CHK : IDLE;
                end
            end
            CHK: begin
                if (new_mode != sel_sgmii) begin
                    sel_nxt   = new_mode;
                    rst_nxt   = RST_W'(RST_CYC - 1);
                    state_nxt = RST;
                end else begin
                    state_nxt = DONE;
                end
            end
            RST: begin
                if (rst_cnt == '0) state_nxt = DONE;
                else               rst_nxt   = rst_cnt - RST_W'(1);
            end
            DONE: begin
                if (!sig) begin
                    state_nxt = IDLE;
                end else if (ovr_en && (ovr_val != ovr_q)) begin
                    mode_nxt  = ovr_val;
                    state_nxt = CHK;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req     = (state == REQ) && sig;
    assign rst_act = (state == RST);
    assign ready   = (state == DONE);

endmodule

module sfp_link_mgr #(
    parameter int CHANNELS = 2,
    parameter int DEB_CYC  = 20_000_000,
    parameter int RST_CYC  = 200_000,
    parameter int MODE_BIT = 3,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CLK,
    input  logic                SYS_RSTn,
    input  logic [CHANNELS-1:0] SIG_DET,
    input  logic [CHANNELS-1:0] MODE_OVR_EN,
    input  logic [CHANNELS-1:0] MODE_OVR_VAL,
    output logic                IIC_REQ,
    output logic [CH_W-1:0]     IIC_CH,
    input  logic                IIC_ACK,
    input  logic                IIC_RVL,
    input  logic [7:0]          IIC_RDT,
    input  logic                IIC_ERR,
    output logic [CHANNELS-1:0] SEL_SGMII,
    output logic [CHANNELS-1:0] PHY_RST,
    output logic [CHANNELS-1:0] CH_READY,
    output logic [CHANNELS-1:0] ID_ERR
);

    localparam int RST_W = $clog2(RST_CYC) + 1;

    typedef struct packed {
        logic vld;
        logic err;
        logic mode;
    } iic_rsp_t;

    logic [RST_W-1:0]    por_cnt;
    logic                por_act;
    logic                busy;
    logic [CH_W-1:0]     rr_ptr;
    logic [CHANNELS-1:0] req_vec, gnt_vec, rst_act;
    logic                found;
    logic [CH_W-1:0]     pick;
    iic_rsp_t            rsp;
    logic                unused_rdt;

    assign unused_rdt = ^IIC_RDT;

    // Every PHY is held in reset for one full pulse after system reset release.
    always_ff @(posedge CLK or negedge SYS_RSTn) begin
        if (!SYS_RSTn)            por_cnt <= RST_W'(RST_CYC);
        else if (por_cnt != '0)   por_cnt <= por_cnt - RST_W'(1);
    end
    assign por_act = (por_cnt != '0);

    assign rsp.vld  = busy && (IIC_RVL || IIC_ERR);
    assign rsp.err  = IIC_ERR;
    assign rsp.mode = IIC_RDT[MODE_BIT];

    // Round-robin: lowest requesting index at or above the pointer, wrapping.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!found && req_vec[idx]) begin
                found = 1'b1;
                pick  = CH_W'(idx);
            end
        end
        gnt_vec = '0;
        for (int k = 0; k < CHANNELS; k++)
            gnt_vec[k] = !busy && found && (pick == CH_W'(k));
    end

    always_ff @(posedge CLK or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            busy    <= 1'b0;
            IIC_REQ <= 1'b0;
            IIC_CH  <= '0;
            rr_ptr  <= '0;
        end else if (!busy) begin
            if (found) begin
                busy    <= 1'b1;
                IIC_REQ <= 1'b1;
                IIC_CH  <= pick;
            end
        end else begin
            if (IIC_ACK) IIC_REQ <= 1'b0;
            if (rsp.vld) begin
                busy    <= 1'b0;
                IIC_REQ <= 1'b0;
                rr_ptr  <= (IIC_CH == CH_W'(CHANNELS - 1)) ? '0 : IIC_CH + CH_W'(1);
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic own;
        assign own = rsp.vld && (IIC_CH == CH_W'(g));

        sfp_link_ch #(
            .DEB_CYC (DEB_CYC),
            .RST_CYC (RST_CYC)
        ) u_ch (
            .gclk      (CLK),
            .grst_n    (SYS_RSTn),
            .sig_det   (SIG_DET[g]),
            .ovr_en    (MODE_OVR_EN[g]),
            .ovr_val   (MODE_OVR_VAL[g]),
            .gnt       (gnt_vec[g]),
            .rvl       (own && !rsp.err),
            .err       (own && rsp.err),
            .rd_bit    (rsp.mode),
            .req       (req_vec[g]),
            .sel_sgmii (SEL_SGMII[g]),
            .rst_act   (rst_act[g]),
            .ready     (CH_READY[g]),
            .id_err    (ID_ERR[g])
        );
    end

    assign PHY_RST = rst_act | {CHANNELS{por_act}};

endmodule

// File: tb/tb_sfp_link_mgr.sv
// Directed bench for sfp_link_mgr: 4 channels, 100-cycle debounce, 10-cycle PHY reset.

module tb_sfp_link_mgr;

    logic       CLK = 1'b0;
    logic       SYS_RSTn = 1'b1;
    logic [3:0] SIG_DET = '0, MODE_OVR_EN = '0, MODE_OVR_VAL = '0;
    logic       IIC_ACK = 1'b0, IIC_RVL = 1'b0, IIC_ERR = 1'b0;
    logic [7:0] IIC_RDT = '0;
    logic       IIC_REQ;
    logic [1:0] IIC_CH;
    logic [3:0] SEL_SGMII, PHY_RST, CH_READY, ID_ERR;

    sfp_link_mgr #(
        .CHANNELS (4),
        .DEB_CYC  (100),
        .RST_CYC  (10),
        .MODE_BIT (3)
    ) dut (
        .CLK          (CLK),
        .SYS_RSTn     (SYS_RSTn),
        .SIG_DET      (SIG_DET),
        .MODE_OVR_EN  (MODE_OVR_EN),
        .MODE_OVR_VAL (MODE_OVR_VAL),
        .IIC_REQ      (IIC_REQ),
        .IIC_CH       (IIC_CH),
        .IIC_ACK      (IIC_ACK),
        .IIC_RVL      (IIC_RVL),
        .IIC_RDT      (IIC_RDT),
        .IIC_ERR      (IIC_ERR),
        .SEL_SGMII    (SEL_SGMII),
        .PHY_RST      (PHY_RST),
        .CH_READY     (CH_READY),
        .ID_ERR       (ID_ERR)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // PHY_RST high-cycle and IIC_REQ rise counters, sampled on the falling edge
    logic mon_en = 1'b0;
    logic req_prev = 1'b0;
    int   hi_cnt[4];
    int   req_rise = 0;

    always @(negedge CLK) begin
        if (mon_en) begin
            for (int i = 0; i < 4; i++) hi_cnt[i] <= hi_cnt[i] + int'(PHY_RST[i]);
            req_rise <= req_rise + int'(IIC_REQ && !req_prev);
            req_prev <= IIC_REQ;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_req(input string tag, input logic [1:0] ch);
        int n = 0;
        while (!IIC_REQ && n < 400) begin
            tick(1);
            n++;
        end
        chk({tag, "_req"}, IIC_REQ, 1);
        chk({tag, "_ch"}, IIC_CH, ch);
    endtask

    task automatic serve(input string tag, input logic rvl, input logic err, input logic [7:0] d);
        IIC_ACK = 1'b1;
        tick(1);
        chk({tag, "_ackdrop"}, IIC_REQ, 0);
        IIC_ACK = 1'b0;
        IIC_RVL = rvl;
        IIC_ERR = err;
        IIC_RDT = d;
        tick(1);
        chk({tag, "_gap"}, IIC_REQ, 0);
        IIC_RVL = 1'b0;
        IIC_ERR = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int b, r;
        #1 SYS_RSTn = 1'b0;
        tick(3);
        chk("rst_sel", SEL_SGMII, 4'h0);
        chk("rst_phy", PHY_RST, 4'hF);
        chk("rst_req", IIC_REQ, 0);
        chk("rst_ch", IIC_CH, 0);
        chk("rst_rdy", CH_READY, 4'h0);
        chk("rst_iderr", ID_ERR, 4'h0);
        SYS_RSTn = 1'b1;
        tick(9);
        chk("por_hold", PHY_RST, 4'hF);
        tick(1);
        chk("por_end", PHY_RST, 4'h0);
        chk("por_req", IIC_REQ, 0);
        mon_en = 1'b1;

        // all four come up together: debounce latency, then grants 0,1,2,3
        SIG_DET = 4'hF;
        tick(103);
        chk("deb_early", IIC_REQ, 0);
        tick(1);
        chk("deb_req", IIC_REQ, 1);
        chk("deb_ch", IIC_CH, 0);
        b = hi_cnt[0];
        serve("g0", 1, 0, 8'h08);
        wait_req("g1", 1);
        serve("g1", 1, 0, 8'h00);
        wait_req("g2", 2);
        serve("g2", 0, 1, 8'hFF);
        wait_req("g3", 3);
        serve("g3", 1, 0, 8'h00);
        tick(15);
        chk("g_pulse0", hi_cnt[0] - b, 10);
        chk("g_sel", SEL_SGMII, 4'b0001);
        chk("g_iderr", ID_ERR, 4'b0100);
        chk("g_rdy", CH_READY, 4'hF);
        chk("g_phy", PHY_RST, 4'h0);

        // re-read of an unchanged ID byte must not pulse the PHY
        SIG_DET[0] = 1'b0;
        tick(4);
        chk("c0_lost", CH_READY, 4'b1110);
        SIG_DET[0] = 1'b1;
        b = hi_cnt[0];
        wait_req("c0r", 0);
        serve("c0r", 1, 0, 8'h08);
        tick(15);
        chk("c0r_pulse", hi_cnt[0] - b, 0);
        chk("c0r_sel", SEL_SGMII, 4'b0001);
        chk("c0r_rdy", CH_READY, 4'hF);

        // one-cycle glitch at cycle 50 restarts the debounce
        SIG_DET[1] = 1'b0;
        tick(4);
        SIG_DET[1] = 1'b1;
        tick(50);
        SIG_DET[1] = 1'b0;
        tick(1);
        SIG_DET[1] = 1'b1;
        tick(103);
        chk("gl_early", IIC_REQ, 0);
        tick(1);
        chk("gl_req", IIC_REQ, 1);
        chk("gl_ch", IIC_CH, 1);
        serve("gl", 1, 0, 8'h00);
        tick(2);
        chk("gl_rdy", CH_READY, 4'hF);

        // pointer now 2: channel 3 beats channel 0; RVL+ERR together counts as error
        SIG_DET[0] = 1'b0;
        SIG_DET[3] = 1'b0;
        tick(4);
        SIG_DET = 4'hF;
        wait_req("rr3", 3);
        serve("rr3", 1, 1, 8'h08);
        wait_req("rr0", 0);
        serve("rr0", 1, 0, 8'h08);
        tick(3);
        chk("rr_iderr", ID_ERR, 4'b1100);
        chk("rr_sel", SEL_SGMII, 4'b0001);
        chk("rr_rdy", CH_READY, 4'hF);

        // stray response with nothing outstanding
        r = req_rise;
        IIC_RVL = 1'b1;
        IIC_ERR = 1'b1;
        tick(1);
        IIC_RVL = 1'b0;
        IIC_ERR = 1'b0;
        tick(2);
        chk("stray_iderr", ID_ERR, 4'b1100);
        chk("stray_req", req_rise - r, 0);

        // channel 2 retry clears its error and switches to SGMII
        SIG_DET[2] = 1'b0;
        tick(4);
        SIG_DET[2] = 1'b1;
        b = hi_cnt[2];
        wait_req("c2r", 2);
        serve("c2r", 1, 0, 8'h08);
        tick(15);
        chk("c2r_iderr", ID_ERR, 4'b1000);
        chk("c2r_sel", SEL_SGMII, 4'b0101);
        chk("c2r_pulse", hi_cnt[2] - b, 10);
        chk("c2r_rdy", CH_READY, 4'hF);

        // override on channel 3: value flip in DONE switches mode without IIC
        MODE_OVR_EN[3] = 1'b1;
        tick(3);
        chk("ovr_en_sel", SEL_SGMII, 4'b0101);
        chk("ovr_en_rdy", CH_READY, 4'hF);
        r = req_rise;
        b = hi_cnt[3];
        MODE_OVR_VAL[3] = 1'b1;
        tick(20);
        chk("ovr_sel", SEL_SGMII, 4'b1101);
        chk("ovr_pulse", hi_cnt[3] - b, 10);
        chk("ovr_noreq", req_rise - r, 0);
        chk("ovr_rdy", CH_READY, 4'hF);
        chk("ovr_iderr", ID_ERR, 4'b1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
